// File: rtl/updown_counter_bank.sv
// Bank of NCH independent up/down counters with wrap/saturate limit, terminal-count
// pulses and a registered one-hot read port with a sticky select-error flag.
module updown_counter_bank #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NCH   = 4,
   parameter int unsigned SAT   = 0,
   parameter int unsigned LIMIT = 2**WIDTH - 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NCH-1:0]   en,
   input  logic [NCH-1:0]   dir,
   input  logic [NCH-1:0]   load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [NCH-1:0]   rd_sel,
   input  logic             clr_err,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_err,
   output logic [NCH-1:0]   tc,
   output logic             any_tc
);

   localparam logic [WIDTH-1:0] LIM      = WIDTH'(LIMIT);
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
   localparam logic             SAT_MODE = (SAT != 0);

   logic [WIDTH-1:0] cnt_q [NCH];
   logic [WIDTH-1:0] cnt_d [NCH];
   logic [NCH-1:0]   tc_d;
   logic [WIDTH-1:0] rd_data_d;
   logic             rd_err_d;
   logic             sel_ok;

   // Per-channel next count: load > enable > hold; bound hit raises tc.
   always_comb begin
      tc_d = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (load[i]) begin
            cnt_d[i] = (load_val > LIM) ? LIM : load_val;
         end else if (en[i]) begin
            if (!dir[i]) begin
               if (cnt_q[i] == LIM) begin
                  tc_d[i]  = 1'b1;
                  cnt_d[i] = SAT_MODE ? LIM : '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + ONE;
               end
            end else begin
               if (cnt_q[i] == '0) begin
                  tc_d[i]  = 1'b1;
                  cnt_d[i] = SAT_MODE ? '0 : LIM;
               end else begin
                  cnt_d[i] = cnt_q[i] - ONE;
               end
            end
         end
      end
   end

   // Read mux on pre-edge counts; invalid select returns all ones and sets the flag.
   always_comb begin
      sel_ok    = $onehot(rd_sel);
      rd_data_d = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (rd_sel[i]) rd_data_d = rd_data_d | cnt_q[i];
      end
      rd_err_d = rd_err;
      if (!sel_ok) begin
         rd_data_d = '1;
         rd_err_d  = 1'b1;
      end else if (clr_err) begin
         rd_err_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NCH; i++) cnt_q[i] <= '0;
         rd_data <= '0;
         rd_err  <= 1'b0;
         tc      <= '0;
         any_tc  <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
         rd_data <= rd_data_d;
         rd_err  <= rd_err_d;
         tc      <= tc_d;
         any_tc  <= |tc_d;
      end
   end

endmodule
